// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, state encoding and output payload for the 8-way round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    typedef struct packed {
        logic [N_REQ-1:0] grant;
        logic [SEL_W-1:0] sel;
        logic             busy;
        logic             timeout;
    } arb_out_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] k);
        onehot = N_REQ'(1) << k;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority search: first set request strictly after ptr, wrapping 7 -> 0.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] cand;

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        idx   = ptr;
        cand  = ptr;
        found = |req;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner of a shared 8:1 bit mux: registered select/grant, bounded tenure, dead cycle on release.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CW       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             timeout
);

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    arb_out_t         out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             hold_exp;
    logic             rel;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (last_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        out_d         = out_q;
        out_d.timeout = 1'b0;
        cnt_d         = cnt_q;
        last_d        = last_q;
        hold_exp      = 1'b0;
        rel           = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    out_d.grant = onehot(pick_idx);
                    out_d.sel   = pick_idx;
                    out_d.busy  = 1'b1;
                    cnt_d       = '0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                hold_exp = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
                rel      = done || !req[out_q.sel] || hold_exp;
                // Timeout is reported only when nothing else would have ended the tenure.
                if (rel) begin
                    out_d.grant   = '0;
                    out_d.busy    = 1'b0;
                    out_d.timeout = hold_exp && !done && req[out_q.sel];
                    last_d        = out_q.sel;
                    cnt_d         = '0;
                    state_d       = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel     = out_q.sel;
    assign grant   = out_q.grant;
    assign busy    = out_q.busy;
    assign timeout = out_q.timeout;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scenario bench for mux8_rr_arbiter (MAX_HOLD=4): per-cycle expectations queued at drive time, checked after the edge.
module tb_mux8_rr_arbiter;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] sel;
        logic       busy;
        logic       timeout;
    } obs_t;

    typedef struct packed {
        logic       r;
        logic [7:0] q;
        logic       d;
        obs_t       e;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;

    obs_t sb[$];
    int   tests  = 0;
    int   failed = 0;
    logic chk_en = 1'b0;

    mux8_rr_arbiter #(.MAX_HOLD(4), .CW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic obs_t g(input int k);
        obs_t o;
        o.grant   = 8'(1) << k;
        o.sel     = 3'(k);
        o.busy    = 1'b1;
        o.timeout = 1'b0;
        return o;
    endfunction

    function automatic obs_t rl(input int k, input logic to);
        obs_t o;
        o.grant   = 8'h00;
        o.sel     = 3'(k);
        o.busy    = 1'b0;
        o.timeout = to;
        return o;
    endfunction

    function automatic obs_t idl(input int k);
        return rl(k, 1'b0);
    endfunction

    function automatic stim_t st(input logic r, input logic [7:0] q, input logic d, input obs_t e);
        stim_t s;
        s.r = r;
        s.q = q;
        s.d = d;
        s.e = e;
        return s;
    endfunction

    // Drive one cycle of inputs, queue what must appear after the next edge, return at the following negedge.
    task automatic tick(input stim_t s);
        rst  = s.r;
        req  = s.q;
        done = s.d;
        sb.push_back(s.e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        stim_t s[$];
        obs_t  act, want;
        s.push_back(st(1'b1, 8'h00, 1'b1, idl(0)));
        s.push_back(st(1'b1, 8'hFF, 1'b0, idl(0)));
        foreach (s[i]) begin
            tick(s[i]);
            act  = {grant, sel, busy, timeout};
            want = sb.pop_front();
            tests++;
            if (act !== want) begin
                failed++;
                $display("FAIL reset[%0d]: got %h/%0d/%b/%b, expected %h/%0d/%b/%b", i,
                         act.grant, act.sel, act.busy, act.timeout, want.grant, want.sel, want.busy, want.timeout);
            end
        end
    endtask

    task automatic test_basic();
        stim_t s[$];
        obs_t  act, want;
        s.push_back(st(1'b0, 8'h01, 1'b0, g(0)));
        s.push_back(st(1'b0, 8'h01, 1'b1, rl(0, 1'b0)));
        s.push_back(st(1'b0, 8'h01, 1'b0, idl(0)));
        s.push_back(st(1'b0, 8'h01, 1'b0, g(0)));
        s.push_back(st(1'b0, 8'h01, 1'b1, rl(0, 1'b0)));
        s.push_back(st(1'b0, 8'h00, 1'b0, idl(0)));
        s.push_back(st(1'b0, 8'h00, 1'b0, idl(0)));
        foreach (s[i]) begin
            tick(s[i]);
            act  = {grant, sel, busy, timeout};
            want = sb.pop_front();
            tests++;
            if (act !== want) begin
                failed++;
                $display("FAIL basic[%0d]: got %h/%0d/%b/%b, expected %h/%0d/%b/%b", i,
                         act.grant, act.sel, act.busy, act.timeout, want.grant, want.sel, want.busy, want.timeout);
            end
        end
    endtask

    task automatic test_round_robin();
        stim_t s[$];
        obs_t  act, want;
        s.push_back(st(1'b1, 8'hFF, 1'b0, idl(0)));
        for (int k = 0; k < 9; k++) begin
            s.push_back(st(1'b0, 8'hFF, 1'b0, g(k % 8)));
            s.push_back(st(1'b0, 8'hFF, 1'b0, g(k % 8)));
            s.push_back(st(1'b0, 8'hFF, 1'b0, g(k % 8)));
            s.push_back(st(1'b0, 8'hFF, 1'b1, rl(k % 8, 1'b0)));
            s.push_back(st(1'b0, 8'hFF, 1'b0, idl(k % 8)));
        end
        foreach (s[i]) begin
            tick(s[i]);
            act  = {grant, sel, busy, timeout};
            want = sb.pop_front();
            tests++;
            if (act !== want) begin
                failed++;
                $display("FAIL round_robin[%0d]: got %h/%0d/%b/%b, expected %h/%0d/%b/%b", i,
                         act.grant, act.sel, act.busy, act.timeout, want.grant, want.sel, want.busy, want.timeout);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t s[$];
        obs_t  act, want;
        s.push_back(st(1'b1, 8'h00, 1'b0, idl(0)));
        s.push_back(st(1'b0, 8'h81, 1'b0, g(0)));
        s.push_back(st(1'b0, 8'h81, 1'b1, rl(0, 1'b0)));
        s.push_back(st(1'b0, 8'h81, 1'b0, idl(0)));
        s.push_back(st(1'b0, 8'h81, 1'b0, g(7)));
        s.push_back(st(1'b0, 8'h81, 1'b1, rl(7, 1'b0)));
        s.push_back(st(1'b0, 8'h00, 1'b1, idl(7)));
        s.push_back(st(1'b0, 8'h00, 1'b1, idl(7)));
        foreach (s[i]) begin
            tick(s[i]);
            act  = {grant, sel, busy, timeout};
            want = sb.pop_front();
            tests++;
            if (act !== want) begin
                failed++;
                $display("FAIL wrap[%0d]: got %h/%0d/%b/%b, expected %h/%0d/%b/%b", i,
                         act.grant, act.sel, act.busy, act.timeout, want.grant, want.sel, want.busy, want.timeout);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t s[$];
        obs_t  act, want;
        for (int k = 0; k < 4; k++) begin
            s.push_back(st(1'b0, 8'h20, 1'b0, g(5)));
        end
        s.push_back(st(1'b0, 8'h20, 1'b0, rl(5, 1'b1)));
        s.push_back(st(1'b0, 8'h20, 1'b0, idl(5)));
        s.push_back(st(1'b0, 8'h20, 1'b0, g(5)));
        s.push_back(st(1'b0, 8'h20, 1'b1, rl(5, 1'b0)));
        s.push_back(st(1'b0, 8'h00, 1'b0, idl(5)));
        foreach (s[i]) begin
            tick(s[i]);
            act  = {grant, sel, busy, timeout};
            want = sb.pop_front();
            tests++;
            if (act !== want) begin
                failed++;
                $display("FAIL timeout[%0d]: got %h/%0d/%b/%b, expected %h/%0d/%b/%b", i,
                         act.grant, act.sel, act.busy, act.timeout, want.grant, want.sel, want.busy, want.timeout);
            end
        end
    endtask

    task automatic test_drop_done();
        stim_t s[$];
        obs_t  act, want;
        s.push_back(st(1'b0, 8'h08, 1'b0, g(3)));
        s.push_back(st(1'b0, 8'h0A, 1'b0, g(3)));
        s.push_back(st(1'b0, 8'h02, 1'b0, rl(3, 1'b0)));
        s.push_back(st(1'b0, 8'h0A, 1'b0, idl(3)));
        s.push_back(st(1'b0, 8'h0A, 1'b0, g(1)));
        s.push_back(st(1'b0, 8'h0A, 1'b1, rl(1, 1'b0)));
        s.push_back(st(1'b0, 8'h08, 1'b0, idl(1)));
        for (int k = 0; k < 4; k++) begin
            s.push_back(st(1'b0, 8'h08, 1'b0, g(3)));
        end
        s.push_back(st(1'b0, 8'h00, 1'b1, rl(3, 1'b0)));
        s.push_back(st(1'b0, 8'h00, 1'b0, idl(3)));
        s.push_back(st(1'b0, 8'h00, 1'b0, idl(3)));
        foreach (s[i]) begin
            tick(s[i]);
            act  = {grant, sel, busy, timeout};
            want = sb.pop_front();
            tests++;
            if (act !== want) begin
                failed++;
                $display("FAIL drop_done[%0d]: got %h/%0d/%b/%b, expected %h/%0d/%b/%b", i,
                         act.grant, act.sel, act.busy, act.timeout, want.grant, want.sel, want.busy, want.timeout);
            end
        end
    endtask

    task automatic test_rst_hold();
        stim_t s[$];
        obs_t  act, want;
        s.push_back(st(1'b1, 8'h00, 1'b0, idl(0)));
        s.push_back(st(1'b0, 8'h40, 1'b0, g(6)));
        s.push_back(st(1'b0, 8'h40, 1'b0, g(6)));
        s.push_back(st(1'b1, 8'hFF, 1'b0, idl(0)));
        s.push_back(st(1'b0, 8'hFF, 1'b0, g(0)));
        s.push_back(st(1'b0, 8'hFF, 1'b1, rl(0, 1'b0)));
        s.push_back(st(1'b0, 8'hFF, 1'b0, idl(0)));
        s.push_back(st(1'b0, 8'hFF, 1'b0, g(1)));
        foreach (s[i]) begin
            tick(s[i]);
            act  = {grant, sel, busy, timeout};
            want = sb.pop_front();
            tests++;
            if (act !== want) begin
                failed++;
                $display("FAIL rst_hold[%0d]: got %h/%0d/%b/%b, expected %h/%0d/%b/%b", i,
                         act.grant, act.sel, act.busy, act.timeout, want.grant, want.sel, want.busy, want.timeout);
            end
        end
    endtask

    // Structural properties of the outputs, sampled every negedge once reset has been applied.
    initial begin
        logic [7:0] prev_grant;
        logic [2:0] prev_sel;
        prev_grant = 8'h00;
        prev_sel   = 3'd0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                tests++;
                if (!$onehot0(grant) || (busy !== (|grant)) || (busy && !grant[sel])) begin
                    failed++;
                    $display("FAIL invariant: grant=%h sel=%0d busy=%b", grant, sel, busy);
                end
                if (prev_grant != 8'h00 && grant != 8'h00) begin
                    tests++;
                    if (sel !== prev_sel) begin
                        failed++;
                        $display("FAIL sel_stable: sel=%0d while granted, required %0d", sel, prev_sel);
                    end
                end
                prev_grant = grant;
                prev_sel   = sel;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        test_reset();
        chk_en = 1'b1;
        test_basic();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_drop_done();
        test_rst_hold();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
